acct_enforcer: RTL
==================

Name: acct_enforcer

Overview:
- Request filter that consumes the packed per-peripheral access-control vector produced by the access-control register block.
- Sits between one initiator and the peripheral crossbar on a simplified valid/ready request/response channel.
- Decodes each request's target peripheral and checks privilege and direction against the 4-bit permission field. Allowed requests are forwarded; denied requests get a locally generated error response.
- Counts violations and latches the first violating address for software.

Parameters:
- NB_PERIPHERALS, 9: number of peripherals, i.e. number of 4-bit permission fields.
- ADDR_WIDTH, 64: request address width.
- DATA_WIDTH, 64: read/write data width.
- PERIPH_SHIFT, 16: LSB of the 4-bit peripheral index field in the address.
- CNT_WIDTH, 16: violation counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- acc_ctrl_i  in  4*NB_PERIPHERALS  permission vector; field p = bits [4p+3:4p]
- us_req_valid_i  in  1  upstream request valid
- us_req_ready_o  out  1  upstream request accepted
- us_req_addr_i  in  ADDR_WIDTH  request address
- us_req_we_i  in  1  1=write, 0=read
- us_req_wdata_i  in  DATA_WIDTH  write data
- us_req_priv_i  in  2  privilege: 0=U, 1=S, 3=M, 2=reserved
- us_rsp_valid_o  out  1  upstream response valid
- us_rsp_ready_i  in  1  upstream response taken
- us_rsp_rdata_o  out  DATA_WIDTH  read data
- us_rsp_err_o  out  1  response error
- ds_req_valid_o  out  1  downstream request valid
- ds_req_ready_i  in  1  downstream request accepted
- ds_req_addr_o / ds_req_we_o / ds_req_wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH  forwarded request
- ds_rsp_valid_i  in  1  downstream response valid
- ds_rsp_ready_o  out  1  downstream response accepted
- ds_rsp_rdata_i  in  DATA_WIDTH  downstream read data
- ds_rsp_err_i  in  1  downstream error
- viol_cnt_o  out  CNT_WIDTH  saturating violation count
- viol_valid_o  out  1  sticky: first violation captured
- viol_addr_o  out  ADDR_WIDTH  address of first violation
- viol_clr_i  in  1  synchronous clear of counter and capture

Behaviour:
- Reset (async, rst_ni low): FSM=IDLE; all valid/ready outputs 0; rdata/err/addr/wdata/we outputs 0; viol_cnt_o=0; viol_valid_o=0; viol_addr_o=0.
- One outstanding transaction. us_req_ready_o=1 only in IDLE; a request is accepted when valid&&ready, and addr/we/wdata/priv are captured into a holding register.
- States:
  - IDLE: on accept -> CHECK.
  - CHECK: one cycle. idx = addr[PERIPH_SHIFT+3:PERIPH_SHIFT]; perm = acc_ctrl_i field idx, sampled this cycle only.
    - Allowed if priv=M; or priv=U and perm bit (we?1:0) set; or priv=S and perm bit (we?3:2) set.
    - Denied if idx>=NB_PERIPHERALS or priv=2.
    - Allowed -> FWD; denied -> ERR.
  - FWD: ds_req_valid_o=1, outputs driven from the holding register and stable until ds_req_ready_i; handshake -> WAIT.
  - WAIT: ds_rsp_ready_o=1; on ds_rsp_valid_i, capture rdata/err -> RSP.
  - ERR: one cycle. Response rdata=0, err=1; violation bookkeeping -> RSP.
  - RSP: us_rsp_valid_o=1, data stable until us_rsp_ready_i; handshake -> IDLE.
- Latency, zero-wait environment: forwarded request reaches ds_req_valid_o 2 cycles after the accept edge. A denied request reaches us_rsp_valid_o 3 cycles after the accept edge.
- Violation bookkeeping, in ERR:
  - viol_cnt_o increments and saturates at all-ones.
  - If viol_valid_o=0, set it and latch viol_addr_o.
  - Later violations do not overwrite viol_addr_o.
- viol_clr_i: counter -> 0, viol_valid_o -> 0, viol_addr_o -> 0. If asserted in the same cycle as ERR, the clear wins and the violation is dropped.
- Permission changes on acc_ctrl_i after CHECK do not affect an in-flight transaction.
- A downstream error is passed through unchanged and is not counted as a violation.
- Reset asserted mid-transaction aborts immediately to IDLE. No response is issued for the aborted request.

Test Plan:
- M-mode reads idx 3 (addr 0x0003_0000) with acc_ctrl_i=0 -> forwarded; ds_req_valid_o 2 cycles after accept; ds rdata 0xDEAD returned with err=0.
- U-mode write to idx 0 with field0=4'b0001 -> denied; us_rsp_err_o=1, rdata=0, viol_cnt_o=1, viol_valid_o=1, viol_addr_o=0x0. Repeat with field0=4'b0010 -> forwarded.
- S-mode read to idx 9 (addr 0x0009_0000), NB_PERIPHERALS=9 -> denied. Second violation at 0x0005_0000 with priv=2 -> viol_cnt_o=2, viol_addr_o stays 0x0009_0000.
- Backpressure: hold ds_req_ready_i=0 for 5 cycles and us_rsp_ready_i=0 for 3 cycles -> outputs stable and us_req_ready_o=0 throughout; completes normally.
- CNT_WIDTH=2: 5 violations -> viol_cnt_o=3. viol_clr_i coincident with ERR -> count 0, viol_valid_o=0.
- Reset pulse while in WAIT -> all outputs return to reset values asynchronously. A new request after reset completes correctly.

Source files
------------

// File: rtl/acct_enforcer.sv
// Access-control request filter: checks each upstream request against its peripheral's
// 4-bit permission field, forwards allowed requests and answers denied ones locally.
module acct_enforcer #(
    parameter int NB_PERIPHERALS = 9,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int PERIPH_SHIFT   = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [4*NB_PERIPHERALS-1:0]   acc_ctrl_i,
    input  logic                          us_req_valid_i,
    output logic                          us_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         us_req_addr_i,
    input  logic                          us_req_we_i,
    input  logic [DATA_WIDTH-1:0]         us_req_wdata_i,
    input  logic [1:0]                    us_req_priv_i,
    output logic                          us_rsp_valid_o,
    input  logic                          us_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         us_rsp_rdata_o,
    output logic                          us_rsp_err_o,
    output logic                          ds_req_valid_o,
    input  logic                          ds_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         ds_req_addr_o,
    output logic                          ds_req_we_o,
    output logic [DATA_WIDTH-1:0]         ds_req_wdata_o,
    input  logic                          ds_rsp_valid_i,
    output logic                          ds_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]         ds_rsp_rdata_i,
    input  logic                          ds_rsp_err_i,
    output logic [CNT_WIDTH-1:0]          viol_cnt_o,
    output logic                          viol_valid_o,
    output logic [ADDR_WIDTH-1:0]         viol_addr_o,
    input  logic                          viol_clr_i
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FWD, S_WAIT, S_ERR, S_RSP} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic [1:0]            priv;
    } req_t;

    state_e                state_q, state_d;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  vvalid_q;
    logic [ADDR_WIDTH-1:0] vaddr_q;

    logic [3:0] idx, perm;
    logic       in_range, rule_ok, allow;

    assign idx = req_q.addr[PERIPH_SHIFT+3:PERIPH_SHIFT];

    // Indices beyond the populated peripherals have no field and are always denied.
    always_comb begin
        perm     = '0;
        in_range = 1'b0;
        for (int p = 0; p < NB_PERIPHERALS; p++) begin
            if (int'(idx) == p) begin
                perm     = acc_ctrl_i[4*p +: 4];
                in_range = 1'b1;
            end
        end
    end

    always_comb begin
        case (req_q.priv)
            2'd3:    rule_ok = 1'b1;
            2'd1:    rule_ok = req_q.we ? perm[3] : perm[2];
            2'd0:    rule_ok = req_q.we ? perm[1] : perm[0];
            default: rule_ok = 1'b0;
        endcase
        allow = in_range && rule_ok;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (us_req_valid_i) state_d = S_CHECK;
            S_CHECK: state_d = allow ? S_FWD : S_ERR;
            S_FWD:   if (ds_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (ds_rsp_valid_i) state_d = S_RSP;
            S_ERR:   state_d = S_RSP;
            S_RSP:   if (us_rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is gated by reset so every handshake output reads 0 while reset is held.
    always_comb begin
        us_req_ready_o = rst_ni && (state_q == S_IDLE);
        ds_req_valid_o = (state_q == S_FWD);
        ds_rsp_ready_o = (state_q == S_WAIT);
        us_rsp_valid_o = (state_q == S_RSP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && us_req_valid_i)
                req_q <= '{addr: us_req_addr_i, we: us_req_we_i,
                           wdata: us_req_wdata_i, priv: us_req_priv_i};
            if (state_q == S_WAIT && ds_rsp_valid_i) begin
                rdata_q <= ds_rsp_rdata_i;
                err_q   <= ds_rsp_err_i;
            end else if (state_q == S_ERR) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // A clear in the same cycle as ERR drops that violation entirely.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            vvalid_q <= 1'b0;
            vaddr_q  <= '0;
        end else if (viol_clr_i) begin
            cnt_q    <= '0;
            vvalid_q <= 1'b0;
            vaddr_q  <= '0;
        end else if (state_q == S_ERR) begin
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (!vvalid_q) begin
                vvalid_q <= 1'b1;
                vaddr_q  <= req_q.addr;
            end
        end
    end

    assign ds_req_addr_o  = req_q.addr;
    assign ds_req_we_o    = req_q.we;
    assign ds_req_wdata_o = req_q.wdata;
    assign us_rsp_rdata_o = rdata_q;
    assign us_rsp_err_o   = err_q;
    assign viol_cnt_o     = cnt_q;
    assign viol_valid_o   = vvalid_q;
    assign viol_addr_o    = vaddr_q;

endmodule
